sensor_packet_framer: RTL and testbench

//  Downstream consumer of the counting circuit and duty-cycle circuit 8-bit results.

---
 rtl/sensor_packet_framer.sv | 207 ++++++++++++++++++++
 tb/tb_sensor_packet_framer.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sensor_packet_framer.sv
// sensor_packet_framer: periodic snapshot of the counting and duty-cycle results,
// framed as HEADER, SEQ, CC, DC, CHK and sent one byte at a time over a tx_start/tx_ready link.
module sensor_packet_framer #(
    parameter int unsigned PERIOD_CYCLES = 100_000_000,
    parameter logic [7:0]  HEADER        = 8'hA5,
    parameter int unsigned ACK_TIMEOUT   = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [7:0] cc_value,
    input  logic [7:0] dc_value,
    input  logic       tx_ready,
    output logic [7:0] tx_data,
    output logic       tx_start,
    output logic       busy,
    output logic       overrun,
    output logic       ack_err
);

    localparam int unsigned TW = $clog2(PERIOD_CYCLES);
    localparam int unsigned AW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(PERIOD_CYCLES - 1);
    localparam logic [AW-1:0] ACK_LAST   = AW'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_ACK,
        WAIT_DONE
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [TW-1:0] timer;
    logic          tick;
    logic [AW-1:0] ack_cnt;
    logic          ack_expired;
    logic [2:0]    idx;
    logic          last_byte;
    logic [7:0]    seq;
    logic [7:0]    cc_snap;
    logic [7:0]    dc_snap;
    logic [7:0]    chk;
    logic [7:0]    pkt_byte;

    logic capture;
    logic load_byte;
    logic next_byte;
    logic pkt_done;
    logic ack_fail;

    assign tick        = (timer == TIMER_LAST);
    assign ack_expired = tx_ready && (ack_cnt == ACK_LAST);
    assign last_byte   = (idx == 3'd4);
    assign chk         = HEADER + seq + cc_snap + dc_snap;
    assign busy        = (state_q != IDLE);

    // Interval timer: free-runs while enabled, wraps after the tick cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timer <= '0;
        end else if (!enable || tick) begin
            timer <= '0;
        end else begin
            timer <= timer + 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a timed-out acknowledge is treated as a sent byte.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (tick) begin
                    state_d = SEND;
                end
            end
            SEND: begin
                if (tx_ready) begin
                    state_d = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (!tx_ready || ack_expired) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (tx_ready) begin
                    state_d = last_byte ? IDLE : SEND;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Per-state control strobes for the datapath registers.
    always_comb begin
        capture   = 1'b0;
        load_byte = 1'b0;
        next_byte = 1'b0;
        pkt_done  = 1'b0;
        ack_fail  = 1'b0;
        unique case (1'b1)
            (state_q == IDLE):     capture   = tick;
            (state_q == SEND):     load_byte = tx_ready;
            (state_q == WAIT_ACK): ack_fail  = ack_expired;
            (state_q == WAIT_DONE): begin
                next_byte = tx_ready && !last_byte;
                pkt_done  = tx_ready && last_byte;
            end
            default: ;
        endcase
    end

    // Byte selector for the packet currently in flight.
    always_comb begin
        unique case (idx)
            3'd0:    pkt_byte = HEADER;
            3'd1:    pkt_byte = seq;
            3'd2:    pkt_byte = cc_snap;
            3'd3:    pkt_byte = dc_snap;
            default: pkt_byte = chk;
        endcase
    end

    // Snapshot of the sensor results, taken only when a packet starts.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cc_snap <= '0;
            dc_snap <= '0;
        end else if (capture) begin
            cc_snap <= cc_value;
            dc_snap <= dc_value;
        end
    end

    // Byte index within the packet.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx <= '0;
        end else if (capture) begin
            idx <= '0;
        end else if (next_byte) begin
            idx <= idx + 3'd1;
        end
    end

    // Transmit register and one-cycle start pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_data  <= '0;
            tx_start <= 1'b0;
        end else begin
            tx_start <= load_byte;
            if (load_byte) begin
                tx_data <= pkt_byte;
            end
        end
    end

    // Acknowledge watchdog, restarted on every byte launch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ack_cnt <= '0;
        end else if (load_byte) begin
            ack_cnt <= '0;
        end else if (state_q == WAIT_ACK && !ack_expired) begin
            ack_cnt <= ack_cnt + 1'b1;
        end
    end

    // Sequence number advances once per completed packet, wrapping at 8 bits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seq <= '0;
        end else if (pkt_done) begin
            seq <= seq + 8'd1;
        end
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overrun <= 1'b0;
            ack_err <= 1'b0;
        end else begin
            if (tick && state_q != IDLE) begin
                overrun <= 1'b1;
            end
            if (ack_fail) begin
                ack_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sensor_packet_framer.sv
// tb_sensor_packet_framer: transaction-level model of the framer plus a reactive
// byte transmitter; directed scenarios followed by a randomized run.
module tb_sensor_packet_framer;

    localparam int PERIOD = 200;
    localparam int ACKTO  = 64;
    localparam logic [7:0] HDR = 8'hA5;
    localparam int OWE   = 0;
    localparam int ACKW  = 1;
    localparam int DONEW = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       enable = 1'b0;
    logic [7:0] cc_value = 8'h00;
    logic [7:0] dc_value = 8'h00;
    logic       tx_ready;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       busy;
    logic       overrun;
    logic       ack_err;

    sensor_packet_framer #(
        .PERIOD_CYCLES(PERIOD),
        .HEADER(HDR),
        .ACK_TIMEOUT(ACKTO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .cc_value(cc_value),
        .dc_value(dc_value),
        .tx_ready(tx_ready),
        .tx_data(tx_data),
        .tx_start(tx_start),
        .busy(busy),
        .overrun(overrun),
        .ack_err(ack_err)
    );

    always #5 clk = ~clk;

    // Byte transmitter: ready drops the cycle after tx_start, returns after 'hold' cycles.
    int   hold = 20;
    bit   stuck = 1'b0;
    int   hcnt = 0;
    logic rdy = 1'b1;
    assign tx_ready = rdy;

    always @(posedge clk) begin
        if (stuck) begin
            rdy  <= 1'b1;
            hcnt <= 0;
        end else if (tx_start) begin
            rdy  <= 1'b0;
            hcnt <= hold;
        end else if (hcnt > 1) begin
            hcnt <= hcnt - 1;
        end else begin
            rdy  <= 1'b1;
            hcnt <= 0;
        end
    end

    int c_vec = 0;
    int c_mis = 0;
    int d_vec = 0;
    int d_mis = 0;
    int cyc = 0;

    logic [7:0] sent[$];
    int first_start = -1;
    int ack_rise = -1;
    int en_rise = -1;
    int rel_cyc = -1;
    bit en_prev = 1'b0;
    bit rst_prev = 1'b0;

    int         m_timer = 0;
    int         m_seq = 0;
    int         m_ph = OWE;
    int         t_sent = 0;
    bit         m_ovr = 1'b0;
    bit         m_ack = 1'b0;
    bit         m_start = 1'b0;
    logic [7:0] m_data = 8'h00;
    logic [7:0] m_q[$];
    bit         tk;
    bit         ns;
    int         sum;

    task automatic report();
        $display("== %0d vectors applied, %0d miscompares ==",
                 c_vec + d_vec, c_mis + d_mis);
    endtask

    task automatic c_chk(input string name, input int act, input int exp);
        c_vec++;
        if (act != exp) begin
            c_mis++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h",
                     name, cyc, act, exp);
        end
    endtask

    task automatic d_chk(input string name, input int act, input int exp);
        d_vec++;
        if (act != exp) begin
            d_mis++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h",
                     name, cyc, act, exp);
        end
    endtask

    // Compare DUT against the model every cycle, then advance the model by one cycle.
    always @(negedge clk) begin
        if (!rst) begin
            c_chk("reset tx_start", tx_start, 0);
            c_chk("reset tx_data", tx_data, 0);
            c_chk("reset busy", busy, 0);
            c_chk("reset overrun", overrun, 0);
            c_chk("reset ack_err", ack_err, 0);
            m_timer = 0;
            m_seq = 0;
            m_ph = OWE;
            m_ovr = 1'b0;
            m_ack = 1'b0;
            m_start = 1'b0;
            m_data = 8'h00;
            m_q.delete();
            sent.delete();
            first_start = -1;
            ack_rise = -1;
        end else begin
            c_chk("tx_start", tx_start, m_start);
            c_chk("tx_data", tx_data, m_data);
            c_chk("busy", busy, m_q.size() != 0);
            c_chk("overrun", overrun, m_ovr);
            c_chk("ack_err", ack_err, m_ack);
            if (rst && !rst_prev) rel_cyc = cyc;
            if (tx_start) begin
                sent.push_back(tx_data);
                if (first_start < 0) first_start = cyc;
            end
            if (ack_err && ack_rise < 0) ack_rise = cyc;

            tk = (m_timer == PERIOD - 1);
            ns = 1'b0;
            if (m_q.size() == 0) begin
                if (tk) begin
                    sum = (int'(HDR) + m_seq + int'(cc_value) + int'(dc_value)) % 256;
                    m_q.push_back(HDR);
                    m_q.push_back(8'(m_seq));
                    m_q.push_back(cc_value);
                    m_q.push_back(dc_value);
                    m_q.push_back(8'(sum));
                    m_ph = OWE;
                end
            end else begin
                if (tk) m_ovr = 1'b1;
                if (m_ph == OWE) begin
                    if (tx_ready) begin
                        ns = 1'b1;
                        m_data = m_q[0];
                        t_sent = cyc + 1;
                        m_ph = ACKW;
                    end
                end else if (m_ph == ACKW) begin
                    if (!tx_ready) begin
                        m_ph = DONEW;
                    end else if (cyc - t_sent == ACKTO - 1) begin
                        m_ack = 1'b1;
                        m_ph = DONEW;
                    end
                end else if (tx_ready) begin
                    void'(m_q.pop_front());
                    if (m_q.size() == 0) m_seq = (m_seq + 1) % 256;
                    else m_ph = OWE;
                end
            end
            m_start = ns;
            m_timer = enable ? (tk ? 0 : m_timer + 1) : 0;
        end
        if (enable && !en_prev) en_rise = cyc;
        en_prev = enable;
        rst_prev = rst;
        cyc++;
        if (c_mis > 100) begin
            report();
            $finish;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step(1);
        rst = 1'b0;
        enable = 1'b0;
        stuck = 1'b0;
        step(3);
        rst = 1'b1;
        step(2);
    endtask

    task automatic wait_bytes(input int n, input int budget);
        int k = 0;
        while (sent.size() < n && k < budget) begin
            @(posedge clk);
            k++;
        end
        #1;
        d_chk("byte wait", sent.size() >= n, 1);
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (busy && k < budget) begin
            @(posedge clk);
            k++;
        end
        #1;
        d_chk("idle wait", busy, 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Reset values and scenario 1: fixed values, two packets.
        step(2);
        d_chk("reset busy", busy, 0);
        d_chk("reset tx_data", tx_data, 0);
        do_reset();
        hold = 20;
        cc_value = 8'h12;
        dc_value = 8'h34;
        enable = 1'b1;
        wait_bytes(10, 3 * PERIOD);
        wait_idle(PERIOD);
        d_chk("t1 byte count", sent.size(), 10);
        d_chk("t1 latency", first_start - en_rise, PERIOD + 1);
        d_chk("t1 p0 hdr", sent[0], 8'hA5);
        d_chk("t1 p0 seq", sent[1], 8'h00);
        d_chk("t1 p0 cc", sent[2], 8'h12);
        d_chk("t1 p0 dc", sent[3], 8'h34);
        d_chk("t1 p0 chk", sent[4], 8'hEB);
        d_chk("t1 p1 hdr", sent[5], 8'hA5);
        d_chk("t1 p1 seq", sent[6], 8'h01);
        d_chk("t1 p1 chk", sent[9], 8'hEC);
        d_chk("t1 overrun", overrun, 0);

        // Scenario 2: checksum wrap and sequence wrap over 257 packets.
        do_reset();
        hold = 2;
        cc_value = 8'hFF;
        dc_value = 8'hFF;
        enable = 1'b1;
        wait_bytes(5, 2 * PERIOD);
        d_chk("t2 chk wrap", sent[4], 8'hA3);
        wait_bytes(257 * 5, 257 * PERIOD + 400);
        d_chk("t2 seq ff", sent[255 * 5 + 1], 8'hFF);
        d_chk("t2 chk ff", sent[255 * 5 + 4], 8'hA2);
        d_chk("t2 seq wrap", sent[256 * 5 + 1], 8'h00);
        d_chk("t2 chk wrap2", sent[256 * 5 + 4], 8'hA3);
        enable = 1'b0;
        wait_idle(PERIOD);

        // Scenario 3: packets longer than the period.
        do_reset();
        hold = 60;
        enable = 1'b1;
        for (int i = 0; i < 1400; i++) begin
            if (i % 50 == 0) begin
                cc_value = 8'($urandom);
                dc_value = 8'($urandom);
            end
            step(1);
        end
        enable = 1'b0;
        wait_idle(600);
        d_chk("t3 overrun", overrun, 1);
        d_chk("t3 whole packets", sent.size() % 5, 0);
        d_chk("t3 some packets", sent.size() >= 10, 1);
        for (int p = 0; p < sent.size() / 5; p++) begin
            d_chk("t3 hdr", sent[5 * p], 8'hA5);
            d_chk("t3 seq", sent[5 * p + 1], p % 256);
            d_chk("t3 chk", sent[5 * p + 4],
                  (int'(sent[5 * p]) + int'(sent[5 * p + 1]) +
                   int'(sent[5 * p + 2]) + int'(sent[5 * p + 3])) % 256);
        end

        // Scenario 4: transmitter never acknowledges.
        do_reset();
        stuck = 1'b1;
        cc_value = 8'h5A;
        dc_value = 8'h3C;
        enable = 1'b1;
        wait_bytes(5, PERIOD + 5 * (ACKTO + 10));
        d_chk("t4 ack_err delay", ack_rise - first_start, ACKTO);
        d_chk("t4 ack_err", ack_err, 1);
        d_chk("t4 hdr", sent[0], 8'hA5);
        d_chk("t4 cc", sent[2], 8'h5A);
        d_chk("t4 chk", sent[4], 8'h3B);
        enable = 1'b0;
        wait_idle(6 * ACKTO);
        stuck = 1'b0;

        // Scenario 5: inputs change while a packet is in flight.
        do_reset();
        hold = 20;
        cc_value = 8'h11;
        dc_value = 8'h22;
        enable = 1'b1;
        wait_bytes(2, 2 * PERIOD);
        cc_value = 8'h33;
        dc_value = 8'h44;
        wait_bytes(10, 3 * PERIOD);
        d_chk("t5 old cc", sent[2], 8'h11);
        d_chk("t5 old dc", sent[3], 8'h22);
        d_chk("t5 new cc", sent[7], 8'h33);
        d_chk("t5 new dc", sent[8], 8'h44);
        d_chk("t5 new chk", sent[9], 8'h1D);

        // Scenario 6: reset while byte 2 is being launched.
        do_reset();
        hold = 20;
        enable = 1'b1;
        wait_bytes(2, 2 * PERIOD);
        for (int k = 0; k < 100 && !tx_start; k++) step(1);
        d_chk("t6 at byte 2 start", tx_start, 1);
        rst = 1'b0;
        #1;
        d_chk("t6 reset tx_start", tx_start, 0);
        d_chk("t6 reset busy", busy, 0);
        step(3);
        rst = 1'b1;
        wait_bytes(5, 2 * PERIOD);
        d_chk("t6 restart latency", first_start - rel_cyc, PERIOD + 1);
        d_chk("t6 restart seq", sent[1], 8'h00);
        enable = 1'b0;
        wait_idle(PERIOD);

        // Randomized run against the model.
        do_reset();
        enable = 1'b1;
        for (int i = 0; i < 9000; i++) begin
            if ($urandom_range(7, 0) == 0) cc_value = 8'($urandom);
            if ($urandom_range(7, 0) == 0) dc_value = 8'($urandom);
            if ($urandom_range(299, 0) == 0) enable = ~enable;
            if ($urandom_range(99, 0) == 0) hold = $urandom_range(70, 1);
            if ($urandom_range(2999, 0) == 0) stuck = ~stuck;
            rst = ($urandom_range(4999, 0) != 0);
            step(1);
        end
        rst = 1'b1;
        enable = 1'b0;
        stuck = 1'b0;
        wait_idle(1000);
        step(2);
        report();
        $finish;
    end

endmodule
